// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile writeback queue.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;

  // Register 31 reads as zero; writes to it are discarded.
  localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

  // One pending writeback: destination register and its result.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wbq_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bus bundle for regfile_wb_queue: producer handshake, regfile write port,
// read-address snoop and occupancy. fwdDataA/fwdDataB exist only when
// REGFILE_WBQ_BYPASS_EN is defined.
interface regfile_wb_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              drain_en;
  logic              write;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] rdAddrA;
  logic [ADDR_W-1:0] rdAddrB;
  logic              hitA;
  logic              hitB;
  logic [CNT_W-1:0]  count;
`ifdef REGFILE_WBQ_BYPASS_EN
  logic [DATA_W-1:0] fwdDataA;
  logic [DATA_W-1:0] fwdDataB;

  modport master (
    output in_valid, in_addr, in_data, drain_en, rdAddrA, rdAddrB,
    input  in_ready, write, wrAddr, wrData, hitA, hitB, count, fwdDataA, fwdDataB
  );

  modport slave (
    input  in_valid, in_addr, in_data, drain_en, rdAddrA, rdAddrB,
    output in_ready, write, wrAddr, wrData, hitA, hitB, count, fwdDataA, fwdDataB
  );
`else
  modport master (
    output in_valid, in_addr, in_data, drain_en, rdAddrA, rdAddrB,
    input  in_ready, write, wrAddr, wrData, hitA, hitB, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, drain_en, rdAddrA, rdAddrB,
    output in_ready, write, wrAddr, wrData, hitA, hitB, count
  );
`endif

endinterface

// File: rtl/regfile_wbq_match.sv
// Address compare of one regfile read port against all queued entries.
// Entries arrive ordered oldest (index 0) to youngest (index DEPTH-1).
// With REGFILE_WBQ_BYPASS_EN defined, also selects the youngest matching data.
module regfile_wbq_match
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] ent_addr [DEPTH],
  input  logic [DEPTH-1:0]  ent_valid,
  output logic              hit
`ifdef REGFILE_WBQ_BYPASS_EN
  ,
  input  logic [DATA_W-1:0] ent_data [DEPTH],
  output logic [DATA_W-1:0] fwd_data
`endif
);

  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path holds a value (no latch).
    hit = 1'b0;
`ifdef REGFILE_WBQ_BYPASS_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k] && (ent_addr[k] == rd_addr) && (rd_addr != ADDR_W'(XZR_ADDR))) begin
        hit = 1'b1;
`ifdef REGFILE_WBQ_BYPASS_EN
        fwd_data = ent_data[k];
`endif
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of regfile_32x64. Buffers results from the
// pipeline and drains one per cycle into the regfile write port when
// drain_en is high. Snoops both read addresses and flags pending writes.
// Optional feature macro: REGFILE_WBQ_BYPASS_EN (youngest-entry forwarding).
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic                clk,
  input logic                reset,
  regfile_wb_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // NOTE: entry storage has no reset; validity comes only from the pointers and count.
  wbq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;

  logic              not_empty;
  logic              pop;
  logic              in_ready;
  logic              enq;
  wbq_entry_t        head;

  logic [ADDR_W-1:0] ord_addr [DEPTH];
  logic [DEPTH-1:0]  ord_valid;
  logic              hit_a;
  logic              hit_b;

  assign not_empty = (count_q != '0);
  assign pop       = not_empty && bus.drain_en;
  // A full queue still accepts when the head leaves in the same cycle.
  assign in_ready  = (count_q < FULL_CNT) || bus.drain_en;
  // Writes to XZR complete the handshake but never occupy a slot.
  assign enq       = bus.in_valid && in_ready && (bus.in_addr != ADDR_W'(XZR_ADDR));
  assign head      = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset drops every queued entry.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(enq) - CNT_W'(pop);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{addr: bus.in_addr, data: bus.in_data};
  end

  // Age-ordered view of the queue for the snoop compare (index 0 = head).
  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    assign ord_addr[k]  = mem[rd_ptr + PTR_W'(k)].addr;
    assign ord_valid[k] = (CNT_W'(k) < count_q);
  end

`ifdef REGFILE_WBQ_BYPASS_EN
  logic [DATA_W-1:0] ord_data [DEPTH];
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ord_data
    assign ord_data[k] = mem[rd_ptr + PTR_W'(k)].data;
  end
`endif

  regfile_wbq_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match_a (
    .rd_addr   (bus.rdAddrA),
    .ent_addr  (ord_addr),
    .ent_valid (ord_valid),
    .hit       (hit_a)
`ifdef REGFILE_WBQ_BYPASS_EN
    ,
    .ent_data  (ord_data),
    .fwd_data  (fwd_a)
`endif
  );

  regfile_wbq_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match_b (
    .rd_addr   (bus.rdAddrB),
    .ent_addr  (ord_addr),
    .ent_valid (ord_valid),
    .hit       (hit_b)
`ifdef REGFILE_WBQ_BYPASS_EN
    ,
    .ent_data  (ord_data),
    .fwd_data  (fwd_b)
`endif
  );

  // Outputs: write port shows the head entry, gated to zero when empty.
  assign bus.in_ready = in_ready;
  assign bus.write    = pop;
  assign bus.wrAddr   = not_empty ? head.addr : '0;
  assign bus.wrData   = not_empty ? head.data : '0;
  assign bus.hitA     = hit_a;
  assign bus.hitB     = hit_b;
  assign bus.count    = count_q;
`ifdef REGFILE_WBQ_BYPASS_EN
  assign bus.fwdDataA = fwd_a;
  assign bus.fwdDataB = fwd_b;
`endif

endmodule
